copro_dispatch: RTL and testbench

Front-end sequencer of the LM32 floating-point coprocessor. Accepts user-instruction commands from the LM32 (IEEE-754 single-precision operands), converts operands to the internal `float` format, issues them to the downstream add/sub/mul arithmetic core over a valid/ready handshake, waits for its result, converts the result back to IEEE and returns it with a one-cycle completion pulse. It is the stage directly upstream of the float arithmetic, and the only block that talks to the CPU.

---
 rtl/float_pack.sv | 25 ++
 rtl/copro_dispatch.sv | 111 +++++++++++
 tb/tb_copro_dispatch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/float_pack.sv
// float_pack: internal float format, IEEE conversion helpers and dispatch enums
package float_pack;
  localparam int Ne = 6;
  localparam int Nm = 16;
  localparam int EBIAS = (1 << (Ne - 1)) - 1;
  typedef logic [Ne+Nm:0] float;
  typedef logic [31:0] float_ieee;
  typedef enum logic [1:0] {ADD, SUB, MUL, RSVD} copro_op_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} copro_state_e;

  // Saturates exponent overflow (and inf/nan) to max-finite, flushes underflow and denormals to signed zero, truncates mantissa
  function automatic float float_ieee2float(input float_ieee x);
    int e;
    e = int'(x[30:23]) - 127 + EBIAS;
    if (x[30:23] == 8'd0 || e < 1) return {x[31], {(Ne+Nm){1'b0}}};
    if (x[30:23] == 8'hFF || e > (1 << Ne) - 1) return {x[31], {(Ne+Nm){1'b1}}};
    return {x[31], e[Ne-1:0], x[22:23-Nm]};
  endfunction

  // Every internal exponent fits the IEEE range, so only zero needs special handling
  function automatic float_ieee float2float_ieee(input float x);
    if (x[Ne+Nm-1:Nm] == '0) return {x[Ne+Nm], 31'd0};
    return {x[Ne+Nm], 8'(int'(x[Ne+Nm-1:Nm]) + 127 - EBIAS), x[Nm-1:0], {(23-Nm){1'b0}}};
  endfunction
endpackage

// File: rtl/copro_dispatch.sv
// copro_dispatch: LM32 FP coprocessor front-end sequencer; COPRO_TIMEOUT_EN enables the WAIT abort counter
module copro_dispatch
  import float_pack::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        user_valid,
  input  logic [10:0] user_opcode,
  input  logic [31:0] user_operand_0,
  input  logic [31:0] user_operand_1,
  output logic [31:0] user_result,
  output logic        user_complete,
  output logic        op_valid,
  output logic [1:0]  op_code,
  output float        op_a,
  output float        op_b,
  input  logic        op_ready,
  input  logic        res_valid,
  input  float        res_data,
  output logic        timeout_o
);
  copro_state_e state, state_n;
  float a_n, b_n;
  logic [1:0] code_n;
  logic [31:0] result_n;
  logic unused;
  assign unused = ^{user_opcode[10:2], TIMEOUT_CYCLES[0]};
`ifdef COPRO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic to_n;
  // WAIT-cycle counter and sticky abort flag
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      cnt <= '0;
      timeout_o <= 1'b0;
    end else begin
      cnt <= cnt_n;
      timeout_o <= to_n;
    end
`else
  assign timeout_o = 1'b0;
`endif
  // Next-state and next-register values; outputs are registered from these
  always_comb begin
    state_n = state;
    a_n = op_a;
    b_n = op_b;
    code_n = op_code;
    result_n = user_result;
`ifdef COPRO_TIMEOUT_EN
    cnt_n = cnt;
    to_n = timeout_o;
`endif
    unique case (state)
      IDLE:
        if (user_valid) begin
          if (copro_op_e'(user_opcode[1:0]) == RSVD) begin
            result_n = 32'd0;
            state_n = DONE;
          end else begin
            a_n = float_ieee2float(user_operand_0);
            b_n = float_ieee2float(user_operand_1);
            code_n = user_opcode[1:0];
            state_n = ISSUE;
          end
        end
      ISSUE: begin
        if (op_ready) state_n = WAIT;
`ifdef COPRO_TIMEOUT_EN
        cnt_n = '0;
`endif
      end
      WAIT: begin
        if (res_valid) begin
          result_n = float2float_ieee(res_data);
          state_n = DONE;
        end
`ifdef COPRO_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          result_n = 32'h7FC0_0000;
          to_n = 1'b1;
          state_n = DONE;
        end else cnt_n = cnt + 1'b1;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  // State, operand and result registers; handshake outputs decoded from the next state
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      op_a <= '0;
      op_b <= '0;
      op_code <= '0;
      user_result <= '0;
      op_valid <= 1'b0;
      user_complete <= 1'b0;
    end else begin
      state <= state_n;
      op_a <= a_n;
      op_b <= b_n;
      op_code <= code_n;
      user_result <= result_n;
      op_valid <= state_n == ISSUE;
      user_complete <= state_n == DONE;
    end
endmodule

// File: tb/tb_copro_dispatch.sv
// tb_copro_dispatch: scoreboard bench for copro_dispatch; COPRO_TIMEOUT_EN adds the abort scenario
module tb_copro_dispatch;
  import float_pack::*;
  logic clk = 1'b0, rst = 1'b1;
  logic user_valid = 1'b0;
  logic [10:0] user_opcode = '0;
  logic [31:0] user_operand_0 = '0, user_operand_1 = '0;
  logic [31:0] user_result;
  logic user_complete, op_valid, op_ready = 1'b0, res_valid = 1'b0, timeout_o;
  logic [1:0] op_code;
  float op_a, op_b, res_data = '0;
  int n_tests = 0, n_fail = 0;
  logic [31:0] sb[$];
  int lat, nv;

  copro_dispatch #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .rst_i(rst), .user_valid(user_valid), .user_opcode(user_opcode),
    .user_operand_0(user_operand_0), .user_operand_1(user_operand_1),
    .user_result(user_result), .user_complete(user_complete), .op_valid(op_valid),
    .op_code(op_code), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if ({user_result, user_complete, op_valid, op_code, op_a, op_b, timeout_o} !== '0) begin
      n_fail++;
      $display("FAIL %s: outputs res=%h cmp=%b v=%b code=%h a=%h b=%h to=%b, required all zero",
               name, user_result, user_complete, op_valid, op_code, op_a, op_b, timeout_o);
    end
  endtask

  task automatic do_op(input logic [10:0] opc, input logic [31:0] a, b, input float ea, eb, rd,
                       input logic [31:0] er, input int stall, input bit nores,
                       output int lat_o, output int nv_o);
    bit res_sent = 0;
    logic [31:0] exp_r;
    lat_o = -1;
    nv_o = 0;
    user_opcode = opc;
    user_operand_0 = a;
    user_operand_1 = b;
    user_valid = 1'b1;
    op_ready = 1'b0;
    sb.push_back(er);
    for (int c = 1; c <= 60 && lat_o < 0; c++) begin
      step();
      res_valid = 1'b0;
      if (op_valid) begin
        nv_o++;
        n_tests++;
        if (op_a !== ea || op_b !== eb || op_code !== opc[1:0]) begin
          n_fail++;
          $display("FAIL issue_operands: a=%h b=%h code=%h, required a=%h b=%h code=%h",
                   op_a, op_b, op_code, ea, eb, opc[1:0]);
        end
        op_ready = nv_o > stall;
      end else begin
        op_ready = 1'b0;
        if (nv_o > 0 && !res_sent && !nores) begin
          res_valid = 1'b1;
          res_data = rd;
          res_sent = 1;
        end
      end
      if (user_complete) begin
        lat_o = c;
        user_valid = 1'b0;
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard: completion with result %h, required no completion", user_result);
        end else begin
          exp_r = sb.pop_front();
          if (user_result !== exp_r) begin
            n_fail++;
            $display("FAIL result: got %h, required %h", user_result, exp_r);
          end
        end
      end
    end
    res_valid = 1'b0;
    op_ready = 1'b0;
    if (lat_o < 0) begin
      n_tests++;
      n_fail++;
      user_valid = 1'b0;
      $display("FAIL completion_timeout: no user_complete in 60 cycles, required one");
    end
  endtask

  task automatic expect_int(input string name, input int got, input int req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset;
    step();
    check_idle_outputs("reset_state");
    rst = 1'b0;
    step();
  endtask

  task automatic test_add;
    do_op(11'd0, 32'h3FC00000, 32'h40100000, 23'h1F8000, 23'h202000, 23'h20E000, 32'h40700000, 0, 0, lat, nv);
    expect_int("add_latency", lat, 3);
    expect_int("add_issue_cycles", nv, 1);
    step();
    step();
    n_tests++;
    if (user_complete !== 1'b0 || user_result !== 32'h40700000) begin
      n_fail++;
      $display("FAIL result_hold: cmp=%b res=%h, required cmp=0 res=40700000", user_complete, user_result);
    end
  endtask

  task automatic test_mul_sub;
    do_op(11'd2, 32'h40000000, 32'h40400000, 23'h200000, 23'h208000, 23'h218000, 32'h40C00000, 0, 0, lat, nv);
    expect_int("mul_latency", lat, 3);
    step();
    do_op(11'h7FD, 32'h40400000, 32'h3F800000, 23'h208000, 23'h1F0000, 23'h200000, 32'h40000000, 0, 0, lat, nv);
    expect_int("sub_upper_bits_latency", lat, 3);
    step();
  endtask

  task automatic test_convert;
    do_op(11'd0, 32'h7F000000, 32'hFF800000, 23'h3FFFFF, 23'h7FFFFF, 23'h7FFFFF, 32'hCFFFFF80, 0, 0, lat, nv);
    step();
    do_op(11'd2, 32'hB0000000, 32'h30800000, 23'h400000, 23'h010000, 23'h400000, 32'h80000000, 0, 0, lat, nv);
    step();
    do_op(11'd1, 32'h3F800001, 32'h00000001, 23'h1F0000, 23'h000000, 23'h010000, 32'h30800000, 0, 0, lat, nv);
    step();
  endtask

  task automatic test_backpressure;
    do_op(11'd0, 32'h3FC00000, 32'h40100000, 23'h1F8000, 23'h202000, 23'h20E000, 32'h40700000, 5, 0, lat, nv);
    expect_int("stall_issue_cycles", nv, 6);
    expect_int("stall_latency", lat, 8);
    step();
  endtask

  task automatic test_reserved;
    do_op(11'd3, 32'h3FC00000, 32'h40100000, 23'h0, 23'h0, 23'h0, 32'h00000000, 0, 0, lat, nv);
    expect_int("rsvd_latency", lat, 1);
    expect_int("rsvd_issue_cycles", nv, 0);
    step();
  endtask

  task automatic test_back_to_back;
    do_op(11'd2, 32'h40000000, 32'h40400000, 23'h200000, 23'h208000, 23'h218000, 32'h40C00000, 0, 0, lat, nv);
    do_op(11'd0, 32'h3FC00000, 32'h40100000, 23'h1F8000, 23'h202000, 23'h20E000, 32'h40700000, 0, 0, lat, nv);
    expect_int("b2b_latency", lat, 4);
    do_op(11'd3, 32'h0, 32'h0, 23'h0, 23'h0, 23'h0, 32'h00000000, 0, 0, lat, nv);
    expect_int("b2b_rsvd_latency", lat, 2);
    step();
  endtask

  task automatic test_timeout;
`ifdef COPRO_TIMEOUT_EN
    do_op(11'd0, 32'h3FC00000, 32'h40100000, 23'h1F8000, 23'h202000, 23'h0, 32'h7FC00000, 0, 1, lat, nv);
    expect_int("timeout_latency", lat, 10);
    expect_int("timeout_flag", int'(timeout_o), 1);
    do_op(11'd2, 32'h40000000, 32'h40400000, 23'h200000, 23'h208000, 23'h218000, 32'h40C00000, 0, 0, lat, nv);
    expect_int("post_timeout_latency", lat, 4);
    step();
    expect_int("timeout_sticky", int'(timeout_o), 1);
`else
    expect_int("timeout_tied_low", int'(timeout_o), 0);
`endif
  endtask

  task automatic test_reset_mid;
    user_opcode = 11'd0;
    user_operand_0 = 32'h3FC00000;
    user_operand_1 = 32'h40100000;
    user_valid = 1'b1;
    op_ready = 1'b1;
    sb.push_back(32'h40700000);
    step();
    step();
    expect_int("mid_in_wait", int'(op_valid), 0);
    user_valid = 1'b0;
    op_ready = 1'b0;
    rst = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    #1;
    rst = 1'b0;
    sb.delete();
    step();
    res_valid = 1'b1;
    res_data = 23'h20E000;
    step();
    res_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_idle_outputs("late_result_ignored");
      step();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_sub();
    test_convert();
    test_backpressure();
    test_reserved();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    expect_int("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
